// File: rtl/param_serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// The final borrow is 1 exactly when a < b; done pulses for one cycle when diff/borrow update.
module param_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // state | meaning
    // IDLE  | waiting for start; diff/borrow hold the last result
    // RUN   | one result bit per clock, LSB first
    // DONE  | one-cycle done pulse, diff/borrow just updated

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs of the operand shift registers
    assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        cnt    <= '0;
                        br     <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {d_bit, res_sh[WIDTH-1:1]};
                    br     <= br_nxt;
                    cnt    <= cnt + 1'b1;
                    // Outputs change only on the last bit so they hold across RUN
                    if (last_bit) begin
                        diff   <= {d_bit, res_sh[WIDTH-1:1]};
                        borrow <= br_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_serial_subtractor.sv
// Self-checking bench for param_serial_subtractor: 4-bit and 8-bit instances checked
// against plain unsigned arithmetic ((a - b) mod 2^W, a < b).
module tb_param_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       borrow8;

    int n_checks;
    int n_fail;

    param_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4)
    );

    param_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one 4-bit operation and reports what the DUT produced; no checking here.
    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv,
                           output logic [3:0] d, output logic br, output int lat,
                           output logic busy_e0, output logic idle_after);
        a4 = av;
        b4 = bv;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        busy_e0 = busy4 && !done4;
        lat = 0;
        while (!done4 && lat < 40) begin
            tick();
            lat++;
        end
        d  = diff4;
        br = borrow4;
        tick();
        idle_after = !busy4 && !done4;
    endtask

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           output logic [7:0] d, output logic br, output int lat);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            tick();
            lat++;
        end
        d  = diff8;
        br = borrow8;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        #2;
        n_checks++;
        if ({busy4, done4, diff4, borrow4} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset4: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy4, done4, diff4, borrow4);
        end
        n_checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h borrow=%b, want all 0", busy8, done8, diff8, borrow8);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] d;
        logic br, be0, ia;
        int lat;
        run_op4(4'b1100, 4'b1010, d, br, lat, be0, ia);
        n_checks++;
        if (be0 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b want 1", be0);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_checks++;
        if ({d, br} !== {4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%b borrow=%b want 0010/0", d, br);
        end
        n_checks++;
        if (ia !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_idle_after: busy=%b done=%b want 0/0", busy4, done4);
        end
    endtask

    task automatic test_wrap_borrow();
        logic [3:0] av [3] = '{4'b0001, 4'b0000, 4'b1001};
        logic [3:0] bv [3] = '{4'b1111, 4'b0001, 4'b1001};
        logic [3:0] ev [3] = '{4'b0010, 4'b1111, 4'b0000};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] d;
        logic br, be0, ia;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op4(av[i], bv[i], d, br, lat, be0, ia);
            n_checks++;
            if ({d, br} !== {ev[i], eb[i]} || lat !== 4) begin
                n_fail++;
                $display("FAIL wrap_%0d: got diff=%b borrow=%b lat=%0d want %b/%b lat=4", i, d, br, lat, ev[i], eb[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dones;
        int lat;
        dones = 0;
        a4 = 4'b0101;
        b4 = 4'b0011;
        start4 = 1'b1;
        tick();
        a4 = 4'b1111;
        b4 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done4) dones++;
        end
        n_checks++;
        if ({done4, diff4, borrow4} !== {1'b1, 4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL ignored_result: got done=%b diff=%b borrow=%b want 1/0010/0", done4, diff4, borrow4);
        end
        tick();
        if (done4) dones++;
        n_checks++;
        if (dones !== 1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_single_done: got %0d pulses busy=%b want 1 pulse busy=0", dones, busy4);
        end
        tick();
        n_checks++;
        if (busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_accept_idle: got busy=%b want 1", busy4);
        end
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if ({diff4, borrow4} !== {4'b1111, 1'b0} || lat !== 4) begin
            n_fail++;
            $display("FAIL ignored_second_op: got diff=%b borrow=%b lat=%0d want 1111/0 lat=4", diff4, borrow4, lat);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] d;
        logic br, be0, ia;
        int lat;
        int dones;
        a4 = 4'b1111;
        b4 = 4'b0001;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy4, done4, diff4, borrow4} !== 7'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b diff=%b borrow=%b want all 0", busy4, done4, diff4, borrow4);
        end
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4 || busy4) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midreset_idle: got %0d busy/done cycles want 0", dones);
        end
        run_op4(4'b0110, 4'b0010, d, br, lat, be0, ia);
        n_checks++;
        if ({d, br} !== {4'b0100, 1'b0} || lat !== 4) begin
            n_fail++;
            $display("FAIL midreset_fresh: got diff=%b borrow=%b lat=%0d want 0100/0 lat=4", d, br, lat);
        end
    endtask

    task automatic test_result_hold();
        int bad;
        int lat;
        bad = 0;
        a4 = 4'b1000;
        b4 = 4'b0001;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            if (diff4 !== 4'b0100) bad++;
            tick();
            lat++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_during_run: %0d cycles with diff != 0100", bad);
        end
        n_checks++;
        if ({diff4, borrow4} !== {4'b0111, 1'b0} || lat !== 4) begin
            n_fail++;
            $display("FAIL hold_result: got diff=%b borrow=%b lat=%0d want 0111/0 lat=4", diff4, borrow4, lat);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (diff4 !== 4'b0111) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_idle: diff changed in idle, now %b want 0111", diff4);
        end
    endtask

    task automatic test_random4();
        logic [3:0] av, bv, d, ed;
        logic br, eb, be0, ia;
        int lat;
        for (int i = 0; i < 20; i++) begin
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15));
            ed = 4'((int'(av) - int'(bv) + 16) % 16);
            eb = (av < bv);
            run_op4(av, bv, d, br, lat, be0, ia);
            n_checks++;
            if ({d, br} !== {ed, eb} || lat !== 4) begin
                n_fail++;
                $display("FAIL rand4 a=%h b=%h: got diff=%h borrow=%b lat=%0d want %h/%b lat=4", av, bv, d, br, lat, ed, eb);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] av, bv, d, ed;
        logic br, eb;
        int lat;
        run_op8(8'h00, 8'h01, d, br, lat);
        n_checks++;
        if ({d, br} !== {8'hFF, 1'b1} || lat !== 8) begin
            n_fail++;
            $display("FAIL w8_wrap: got diff=%h borrow=%b lat=%0d want ff/1 lat=8", d, br, lat);
        end
        for (int i = 0; i < 25; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = (i % 5 == 0) ? av : 8'($urandom_range(0, 255));
            ed = 8'((int'(av) - int'(bv) + 256) % 256);
            eb = (av < bv);
            run_op8(av, bv, d, br, lat);
            n_checks++;
            if ({d, br} !== {ed, eb} || lat !== 8) begin
                n_fail++;
                $display("FAIL rand8 a=%h b=%h: got diff=%h borrow=%b lat=%0d want %h/%b lat=8", av, bv, d, br, lat, ed, eb);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_wrap_borrow();
        test_ignored_start();
        test_reset_mid_op();
        test_result_hold();
        test_random4();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_serial_subtractor.md
Name: param_serial_subtractor

Overview:
- Bit-serial, parameterized subtractor; the inverse-direction companion to the team's parameterized adder.
- Accepts two WIDTH-bit operands on a start pulse and computes diff = a - b LSB-first, one bit per clock.
- Reports the final borrow and pulses done when the result is valid.
- Used where area matters more than latency, and as a self-check partner for adder datapaths (a + b - b == a).

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse, result valid
- diff  output  WIDTH  a - b mod 2^WIDTH; held until next accepted start
- borrow  output  1  1 iff a < b (unsigned); held with diff

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values (rst_n low, immediate, no clock needed): state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift registers, bit counter and borrow flop = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge (E0) latches a and b into shift registers, clears the borrow flop and counter, then moves to RUN.
  - start=0: stay in IDLE.
- RUN, edges E1..E_WIDTH, bit i = counter:
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d_i shifts into the MSB of the result shift register; operand registers shift right; counter increments.
  - At E_WIDTH (counter == WIDTH-1): diff <= completed result, borrow <= br_next, state -> DONE.
- DONE: done=1 for exactly the one cycle between E_WIDTH and E_WIDTH+1. At E_WIDTH+1 the state moves to IDLE and done returns to 0.
- Latency: done goes high WIDTH edges after the start edge. Throughput: one operation per WIDTH+2 cycles.
- busy=1 from the edge after E0 through the DONE cycle; 0 in IDLE.
- start while busy (RUN or DONE): ignored. It is not queued, and operands are not recaptured.
- a and b may change freely after E0 without affecting the result.
- diff and borrow outputs update only at E_WIDTH. They hold the previous result throughout RUN and stay stable in IDLE until the next completion.
- Reset asserted mid-operation: the operation is aborted, all outputs return to reset values, no done pulse is produced, and the block is in IDLE after release.
- Arithmetic is unsigned, modulo 2^WIDTH. Equal operands give diff=0, borrow=0.

Test Plan (WIDTH=4 unless noted):
1. Basic: a=1100, b=1010, start one cycle -> busy=1; done exactly 4 edges after the start edge; diff=0010, borrow=0; busy=0 the next cycle.
2. Wrap and borrow: a=0001, b=1111 -> diff=0010, borrow=1. Then a=0000, b=0001 -> diff=1111, borrow=1. Then a=1001, b=1001 -> diff=0000, borrow=0.
3. Ignored start: start held high for the entire operation of a=0101, b=0011, with a and b changed to 1111/0000 after E0 -> diff=0010, borrow=0, a single done pulse. Start is ignored in the DONE cycle and accepted in the following IDLE cycle.
4. Reset mid-op: a=1111, b=0001, start, drop rst_n after 2 edges -> diff=0, borrow=0, busy=0, done=0 immediately. After release the block stays idle with no spurious done; a fresh start with a=0110, b=0010 gives diff=0100.
5. Result hold: after a completion with diff=0100, run a second op of a=1000, b=0001 -> diff stays 0100 through RUN, then becomes 0111, borrow=0, at done.
6. WIDTH=8 instance: a=0x00, b=0x01 -> done 8 edges after start; diff=0xFF, borrow=1. Self-check: sweep random a and b against (a - b) mod 256 and (a < b).
